// File: rtl/is_pkg.sv
// Shared constants for the issue-to-RF receive stage: packet field positions,
// functional-unit ready bit indices and the ALU1 branch-tracking state type.
package is_pkg;

  localparam int unsigned IS_INST_WIDTH    = 66;
  localparam int unsigned ISQ_DEPTH        = 64;
  localparam int unsigned ISQ_IDX_BITS_NUM = 6;

  localparam int unsigned PKT_VLD_BIT = 65;
  localparam int unsigned PKT_IDX_MSB = 64;
  localparam int unsigned PKT_IDX_LSB = 59;
  localparam int unsigned PKT_BR_MSB  = 20;
  localparam int unsigned PKT_BR_LSB  = 19;
  localparam int unsigned PKT_JMP_BIT = 18;

  localparam int unsigned FUN_MUL_BIT  = 0;
  localparam int unsigned FUN_ADD1_BIT = 1;
  localparam int unsigned FUN_ADD2_BIT = 2;
  localparam int unsigned FUN_ADR_BIT  = 3;

  typedef logic [0:0] br_state_t;
  localparam br_state_t StIdle   = 1'b0;
  localparam br_state_t StBrPend = 1'b1;

endpackage

// File: rtl/iss_port_reg.sv
// One RF-stage packet register: loads an accepted packet, holds under stall,
// and drops only the valid bit on flush so the payload stays observable.
module iss_port_reg #(
  parameter int unsigned Width  = 66,
  parameter int unsigned VldBit = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             load,
  input  logic [Width-1:0] pkt_in,
  output logic [Width-1:0] pkt_out
);

  logic [Width-1:0] pkt_d;
  logic [Width-1:0] pkt_q;

  always_comb begin
    pkt_d = '0;
    if (flush) begin
      pkt_d         = pkt_q;
      pkt_d[VldBit] = 1'b0;
    end else if (hold) begin
      pkt_d = pkt_q;
    end else if (load) begin
      pkt_d = pkt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_out = pkt_q;

endmodule

// File: rtl/rf_iss_rcv.sv
// RF-stage receiver for the four issue ports: gates acceptance on unit readiness,
// tracks multiplier occupancy and defers ALU1 issue behind an unresolved branch.
module rf_iss_rcv #(
  parameter int unsigned IS_INST_WIDTH    = is_pkg::IS_INST_WIDTH,
  parameter int unsigned ISQ_DEPTH        = is_pkg::ISQ_DEPTH,
  parameter int unsigned ISQ_IDX_BITS_NUM = is_pkg::ISQ_IDX_BITS_NUM,
  parameter int unsigned MULT_LAT         = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IS_INST_WIDTH-1:0] mul_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu1_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu2_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] adr_ins_to_rf,
  input  logic                     stall_frm_exe,
  input  logic                     mem_stall,
  input  logic                     flush,
  input  logic                     br_res_vld,
  output logic [IS_INST_WIDTH-1:0] mul_ins_rf,
  output logic [IS_INST_WIDTH-1:0] alu1_ins_rf,
  output logic [IS_INST_WIDTH-1:0] alu2_ins_rf,
  output logic [IS_INST_WIDTH-1:0] adr_ins_rf,
  output logic [3:0]               fun_rdy_frm_exe,
  output logic [ISQ_DEPTH-1:0]     clr_br_wat
);

  import is_pkg::*;

  localparam logic [1:0] MulReload = 2'(MULT_LAT - 1);
  localparam logic [ISQ_DEPTH-1:0] OneHotBase = {{(ISQ_DEPTH-1){1'b0}}, 1'b1};

  logic [1:0]                  mul_cnt_d, mul_cnt_q;
  br_state_t                   br_state_d, br_state_q;
  logic [ISQ_IDX_BITS_NUM-1:0] br_idx_d, br_idx_q;
  logic [ISQ_DEPTH-1:0]        clr_d, clr_q;

  logic acc_mul, acc_alu1, acc_alu2, acc_adr;
  logic alu1_is_br;
  logic adr_hold;

  // Readiness is a pure function of current occupancy and the stall inputs.
  always_comb begin
    fun_rdy_frm_exe               = 4'b0000;
    fun_rdy_frm_exe[FUN_MUL_BIT]  = !stall_frm_exe && (mul_cnt_q == 2'd0);
    fun_rdy_frm_exe[FUN_ADD1_BIT] = !stall_frm_exe && (br_state_q == StIdle);
    fun_rdy_frm_exe[FUN_ADD2_BIT] = !stall_frm_exe;
    fun_rdy_frm_exe[FUN_ADR_BIT]  = !stall_frm_exe && !mem_stall;
  end

  always_comb begin
    acc_mul  = mul_ins_to_rf[PKT_VLD_BIT]  && fun_rdy_frm_exe[FUN_MUL_BIT]  && !flush;
    acc_alu1 = alu1_ins_to_rf[PKT_VLD_BIT] && fun_rdy_frm_exe[FUN_ADD1_BIT] && !flush;
    acc_alu2 = alu2_ins_to_rf[PKT_VLD_BIT] && fun_rdy_frm_exe[FUN_ADD2_BIT] && !flush;
    acc_adr  = adr_ins_to_rf[PKT_VLD_BIT]  && fun_rdy_frm_exe[FUN_ADR_BIT]  && !flush;
    alu1_is_br = (alu1_ins_to_rf[PKT_BR_MSB:PKT_BR_LSB] != 2'b00) ||
                 alu1_ins_to_rf[PKT_JMP_BIT];
    adr_hold = stall_frm_exe || mem_stall;
  end

  // Occupancy keeps counting down through stalls; only flush cuts it short.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (flush) begin
      mul_cnt_d = 2'd0;
    end else if (acc_mul) begin
      mul_cnt_d = MulReload;
    end else if (mul_cnt_q != 2'd0) begin
      mul_cnt_d = mul_cnt_q - 2'd1;
    end
  end

  always_comb begin
    br_state_d = br_state_q;
    br_idx_d   = br_idx_q;
    clr_d      = '0;
    case (br_state_q)
      StIdle: begin
        if (acc_alu1 && alu1_is_br) begin
          br_state_d = StBrPend;
          br_idx_d   = alu1_ins_to_rf[PKT_IDX_LSB +: ISQ_IDX_BITS_NUM];
        end
      end
      StBrPend: begin
        if (flush) begin
          br_state_d = StIdle;
        end else if (br_res_vld) begin
          br_state_d = StIdle;
          clr_d      = OneHotBase << br_idx_q;
        end
      end
      default: br_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt_q  <= 2'd0;
      br_state_q <= StIdle;
      br_idx_q   <= '0;
      clr_q      <= '0;
    end else begin
      mul_cnt_q  <= mul_cnt_d;
      br_state_q <= br_state_d;
      br_idx_q   <= br_idx_d;
      clr_q      <= clr_d;
    end
  end

  assign clr_br_wat = clr_q;

  iss_port_reg #(
    .Width (IS_INST_WIDTH),
    .VldBit(PKT_VLD_BIT)
  ) u_mul_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .hold   (stall_frm_exe),
    .load   (acc_mul),
    .pkt_in (mul_ins_to_rf),
    .pkt_out(mul_ins_rf)
  );

  iss_port_reg #(
    .Width (IS_INST_WIDTH),
    .VldBit(PKT_VLD_BIT)
  ) u_alu1_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .hold   (stall_frm_exe),
    .load   (acc_alu1),
    .pkt_in (alu1_ins_to_rf),
    .pkt_out(alu1_ins_rf)
  );

  iss_port_reg #(
    .Width (IS_INST_WIDTH),
    .VldBit(PKT_VLD_BIT)
  ) u_alu2_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .hold   (stall_frm_exe),
    .load   (acc_alu2),
    .pkt_in (alu2_ins_to_rf),
    .pkt_out(alu2_ins_rf)
  );

  iss_port_reg #(
    .Width (IS_INST_WIDTH),
    .VldBit(PKT_VLD_BIT)
  ) u_adr_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .hold   (adr_hold),
    .load   (acc_adr),
    .pkt_in (adr_ins_to_rf),
    .pkt_out(adr_ins_rf)
  );

endmodule

// File: tb/tb_rf_iss_rcv.sv
// Directed bench for rf_iss_rcv: a cycle-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rf_iss_rcv;

  localparam int W  = 66;
  localparam int D  = 64;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] mul_i, alu1_i, alu2_i, adr_i;
  logic         stall, mem_stall, flush, br_res;
  logic [W-1:0] mul_o, alu1_o, alu2_o, adr_o;
  logic [3:0]   rdy;
  logic [D-1:0] clr;

  always #5 clk = ~clk;

  rf_iss_rcv #(
    .IS_INST_WIDTH   (W),
    .ISQ_DEPTH       (D),
    .ISQ_IDX_BITS_NUM(6),
    .MULT_LAT        (ML)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mul_ins_to_rf  (mul_i),
    .alu1_ins_to_rf (alu1_i),
    .alu2_ins_to_rf (alu2_i),
    .adr_ins_to_rf  (adr_i),
    .stall_frm_exe  (stall),
    .mem_stall      (mem_stall),
    .flush          (flush),
    .br_res_vld     (br_res),
    .mul_ins_rf     (mul_o),
    .alu1_ins_rf    (alu1_o),
    .alu2_ins_rf    (alu2_o),
    .adr_ins_rf     (adr_o),
    .fun_rdy_frm_exe(rdy),
    .clr_br_wat     (clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit v, input int idx, input logic [1:0] br,
                                      input bit j);
    logic [W-1:0] p;
    p        = '0;
    p[58:21] = 38'h15_5555_5555;
    p[17:0]  = 18'(idx * 37 + 1);
    p[65]    = v;
    p[64:59] = 6'(idx);
    p[20:19] = br;
    p[18]    = j;
    return p;
  endfunction

  // Reference model: what each unit holds and which branch is outstanding.
  logic [W-1:0] m_out [4];
  int           m_cnt;
  bit           m_pend;
  int           m_idx;
  logic [D-1:0] m_clr;
  bit           m_live = 1'b0;

  function automatic logic [W-1:0] pin(input int i);
    case (i)
      0: return mul_i;
      1: return alu1_i;
      2: return alu2_i;
      default: return adr_i;
    endcase
  endfunction

  function automatic bit m_rdy(input int i);
    if (stall) return 1'b0;
    case (i)
      0: return m_cnt == 0;
      1: return !m_pend;
      2: return 1'b1;
      default: return !mem_stall;
    endcase
  endfunction

  function automatic bit acc(input int i);
    logic [W-1:0] p;
    p = pin(i);
    return p[65] && m_rdy(i) && !flush;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_out[i] <= '0;
      m_cnt  <= 0;
      m_pend <= 1'b0;
      m_idx  <= 0;
      m_clr  <= '0;
      m_live <= 1'b1;
    end else if (m_live) begin
      for (int i = 0; i < 4; i++) begin
        if (flush) m_out[i] <= {1'b0, m_out[i][64:0]};
        else if (stall || (i == 3 && mem_stall)) m_out[i] <= m_out[i];
        else if (acc(i)) m_out[i] <= pin(i);
        else m_out[i] <= '0;
      end
      if (flush) m_cnt <= 0;
      else if (acc(0)) m_cnt <= ML - 1;
      else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      m_clr <= (m_pend && br_res && !flush) ? (64'd1 << m_idx) : '0;
      if (flush) m_pend <= 1'b0;
      else if (m_pend) begin
        if (br_res) m_pend <= 1'b0;
      end else if (acc(1) && (alu1_i[20:19] != 2'b00 || alu1_i[18])) begin
        m_pend <= 1'b1;
        m_idx  <= int'(alu1_i[64:59]);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && rst_n) begin
      chk("model_mul", mul_o, m_out[0]);
      chk("model_alu1", alu1_o, m_out[1]);
      chk("model_alu2", alu2_o, m_out[2]);
      chk("model_adr", adr_o, m_out[3]);
      chk("model_rdy", W'(rdy), W'({m_rdy(3), m_rdy(2), m_rdy(1), m_rdy(0)}));
      chk("model_clr", W'(clr), W'(m_clr));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    mul_i = '0; alu1_i = '0; alu2_i = '0; adr_i = '0;
    stall = 1'b0; mem_stall = 1'b0; flush = 1'b0; br_res = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    mul_i = '0; alu1_i = '0; alu2_i = '0; adr_i = '0;
    stall = 1'b0; mem_stall = 1'b0; flush = 1'b0; br_res = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    next();
    @(negedge clk);
    chk("rst_mul", mul_o, '0);
    chk("rst_alu1", alu1_o, '0);
    chk("rst_adr", adr_o, '0);
    chk("rst_rdy", W'(rdy), W'(4'b1111));
    chk("rst_clr", W'(clr), '0);

    // Multiplier occupancy, second offer during busy window is dropped
    next(); mul_i = mk(1, 5, 2'b00, 0);
    @(negedge clk); chk("mul_rdy_c0", W'(rdy[0]), W'(1));
    next();
    @(negedge clk);
    chk("mul_vld_c1", W'(mul_o[65]), W'(1));
    chk("mul_idx_c1", W'(mul_o[64:59]), W'(5));
    chk("mul_rdy_c1", W'(rdy[0]), W'(0));
    next(); mul_i = mk(1, 9, 2'b00, 0);
    @(negedge clk);
    chk("mul_rdy_c2", W'(rdy[0]), W'(0));
    chk("mul_one_cycle", mul_o, '0);
    next();
    @(negedge clk);
    chk("mul_dropped_c3", mul_o, '0);
    chk("mul_rdy_c3", W'(rdy[0]), W'(1));

    // Branch deferral on ALU1, resolved four cycles after issue
    next(); alu1_i = mk(1, 12, 2'b01, 0);
    @(negedge clk); chk("br_rdy_c0", W'(rdy[1]), W'(1));
    next(); alu1_i = mk(1, 13, 2'b00, 0);
    @(negedge clk); chk("br_rdy_c1", W'(rdy[1]), W'(0));
    next();
    next();
    @(negedge clk); chk("br_rdy_c3", W'(rdy[1]), W'(0));
    next(); br_res = 1'b1;
    @(negedge clk);
    chk("br_rdy_c4", W'(rdy[1]), W'(0));
    chk("br_clr_c4", W'(clr), '0);
    next();
    @(negedge clk);
    chk("br_clr_pulse", W'(clr), W'(64'h1000));
    chk("br_rdy_c5", W'(rdy[1]), W'(1));
    next();
    @(negedge clk); chk("br_clr_gone", W'(clr), '0);

    // Plain add on ALU1 leaves the branch tracker idle
    next(); alu1_i = mk(1, 3, 2'b00, 0);
    next();
    @(negedge clk);
    chk("add_out", alu1_o, mk(1, 3, 2'b00, 0));
    chk("add_rdy_c1", W'(rdy[1]), W'(1));
    next();
    @(negedge clk);
    chk("add_rdy_c2", W'(rdy[1]), W'(1));
    chk("add_no_clr", W'(clr), '0);

    // Global stall holds the address register for three cycles
    next(); adr_i = mk(1, 7, 2'b00, 0);
    for (int c = 1; c <= 3; c++) begin
      next(); stall = 1'b1; adr_i = mk(1, 8, 2'b00, 0);
      @(negedge clk);
      chk("stall_adr_held", adr_o, mk(1, 7, 2'b00, 0));
      chk("stall_rdy", W'(rdy), W'(4'b0000));
    end
    next();
    @(negedge clk);
    chk("stall_adr_last", adr_o, mk(1, 7, 2'b00, 0));
    chk("stall_rdy_back", W'(rdy), W'(4'b1111));
    next();
    @(negedge clk); chk("stall_adr_clr", adr_o, '0);

    // Memory stall only affects the address unit
    next(); adr_i = mk(1, 2, 2'b00, 0);
    next(); mem_stall = 1'b1;
    @(negedge clk); chk("mstall_rdy", W'(rdy), W'(4'b0111));
    next();
    @(negedge clk); chk("mstall_held", adr_o, mk(1, 2, 2'b00, 0));
    next();
    @(negedge clk); chk("mstall_clr", adr_o, '0);

    // Flush with branch pending, mult busy, and a coincident resolve + issue
    next(); alu1_i = mk(1, 20, 2'b10, 0); mul_i = mk(1, 4, 2'b00, 0);
    next(); flush = 1'b1; br_res = 1'b1; alu2_i = mk(1, 6, 2'b00, 0);
    @(negedge clk);
    chk("fl_pre_rdy", W'(rdy), W'(4'b1100));
    next();
    @(negedge clk);
    chk("fl_mul_vld", W'(mul_o[65]), W'(0));
    chk("fl_alu1_vld", W'(alu1_o[65]), W'(0));
    chk("fl_alu2_vld", W'(alu2_o[65]), W'(0));
    chk("fl_adr_vld", W'(adr_o[65]), W'(0));
    chk("fl_clr", W'(clr), '0);
    chk("fl_rdy", W'(rdy), W'(4'b1111));
    next();
    @(negedge clk); chk("fl_clr_after", W'(clr), '0);

    // Reset while a jump is pending; a later resolve in idle is ignored
    next(); alu1_i = mk(1, 33, 2'b00, 1); mul_i = mk(1, 1, 2'b00, 0);
    next(); rst_n = 1'b0;
    next(); br_res = 1'b1;
    @(negedge clk);
    chk("rr_mul", mul_o, '0);
    chk("rr_alu1", alu1_o, '0);
    chk("rr_alu2", alu2_o, '0);
    chk("rr_adr", adr_o, '0);
    chk("rr_rdy", W'(rdy), W'(4'b1111));
    chk("rr_clr", W'(clr), '0);
    next();
    @(negedge clk);
    chk("rr_clr_after", W'(clr), '0);
    chk("rr_rdy_after", W'(rdy), W'(4'b1111));

    next();
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_iss_rcv.md
RF_ISS_RCV -- requirements
Module: rf_iss_rcv

Interface
REQ-001 SHALL have parameter IS_INST_WIDTH, default 66, as the issued-packet width.
REQ-002 SHALL have parameter ISQ_DEPTH, default 64, as the number of issue-queue lines.
REQ-003 SHALL have parameter ISQ_IDX_BITS_NUM, default 6, as the width of the packet index field.
REQ-004 SHALL have parameter MULT_LAT, default 3, as the multiplier occupancy in cycles (legal range 1..4).
REQ-005 SHALL use one clock; reset is synchronous and active-low; the ports are clk and rst_n.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 SHALL have ports mul_ins_to_rf, alu1_ins_to_rf, alu2_ins_to_rf, adr_ins_to_rf, each input, IS_INST_WIDTH bits: issued packets.
 - Packet bit 65 is inst vld.
 - Packet bits 64:59 are the ISQ index.
 - Packet bits 20:19 are BR.
 - Packet bit 18 is JMP vld.
REQ-009 SHALL have port stall_frm_exe, input, 1 bit: global execute backpressure.
REQ-010 SHALL have port mem_stall, input, 1 bit: address/memory unit backpressure.
REQ-011 SHALL have port flush, input, 1 bit: squash all in-flight state.
REQ-012 SHALL have port br_res_vld, input, 1 bit: outstanding branch/jump resolved this cycle.
REQ-013 SHALL have ports mul_ins_rf, alu1_ins_rf, alu2_ins_rf, adr_ins_rf, each output, IS_INST_WIDTH bits: registered RF-stage packets.
REQ-014 SHALL have port fun_rdy_frm_exe, output, 4 bits: unit ready flags; bit0 mult, bit1 add1, bit2 add2, bit3 addr.
REQ-015 SHALL have port clr_br_wat, output, ISQ_DEPTH bits: one-hot deferred wait-clear for a resolved branch/jump.

Function
REQ-016 SHALL accept a port packet only when its vld bit is 1, the matching fun_rdy_frm_exe bit was 1 in the same cycle, and flush is 0.
 - Any other valid packet is dropped silently.
REQ-017 SHALL register an accepted packet at the next rising edge.
 - Output latency is 1 cycle.
 - Each output packet is valid for exactly 1 cycle unless it is held by stall.
REQ-018 SHALL load an output register with all-zero when the register is not holding and its port has no accepted packet.
REQ-019 SHALL hold all four output registers and drive fun_rdy_frm_exe to 4'b0000 while stall_frm_exe=1.
REQ-020 SHALL hold adr_ins_rf and drive fun_rdy_frm_exe[3]=0 while mem_stall=1.
REQ-021 SHALL drive fun_rdy_frm_exe[0]=1 only when stall_frm_exe=0 and mult counter=0.
REQ-022 SHALL load the mult counter with MULT_LAT-1 on an accepted mult packet.
 - Otherwise the counter decrements by 1 every cycle while nonzero, regardless of stall.
 - With MULT_LAT=3, issue at cycle 0 makes fun_rdy_frm_exe[0] low in cycles 1 and 2 and high in cycle 3.
REQ-023 SHALL implement the ALU1 branch FSM with states IDLE and BR_PEND.
 - IDLE->BR_PEND: an accepted alu1 packet with BR!=2'b00 or JMP vld=1; index bits 64:59 are latched.
 - BR_PEND->IDLE: br_res_vld=1 or flush=1.
REQ-024 SHALL drive fun_rdy_frm_exe[1]=0 in BR_PEND; fun_rdy_frm_exe[2] depends on stall_frm_exe only.
REQ-025 SHALL pulse clr_br_wat=1<<latched index for 1 cycle, registered, after a BR_PEND->IDLE transition caused by br_res_vld=1 with flush=0.
 - clr_br_wat is 0 otherwise.
REQ-026 SHALL ignore br_res_vld in IDLE.
REQ-027 SHALL, on flush=1, do all of the following at the next edge:
 - clear the vld bit of all four output registers;
 - set the mult counter to 0;
 - move the FSM to IDLE;
 - suppress clr_br_wat;
 - flush overrides stall_frm_exe and mem_stall.
REQ-028 SHALL let a flush in the same cycle as a new issue drop that packet.
REQ-029 SHALL let flush and br_res_vld in the same cycle produce IDLE with no clr_br_wat pulse.

Reset
REQ-030 SHALL, when rst_n=0 at a rising edge, clear:
 - all output packet registers to 0;
 - the mult counter to 0;
 - the FSM to IDLE;
 - the latched index to 0;
 - clr_br_wat to 0.
REQ-031 SHALL drive fun_rdy_frm_exe=4'b1111 in the first cycle after reset deassertion if both stalls are 0.
REQ-032 SHALL let reset mid-operation abandon any pending branch or mult occupancy without a clr_br_wat pulse.

Structure
REQ-033 SHALL place the following constants in shared package is_pkg:
 - IS_INST_WIDTH, ISQ_DEPTH, ISQ_IDX_BITS_NUM;
 - packet bit positions (vld 65, idx 64:59, BR 20:19, JMP 18);
 - FUN_*_BIT indices;
 - the FSM state type.
REQ-034 SHALL instantiate sub-module iss_port_reg four times: one packet register with load, hold, and vld-clear on flush.

Verification
REQ-035 Bench SHALL cover mult back-to-back: valid mult packet idx 5 at cycle 0.
 - mul_ins_rf valid with idx 5 at cycle 1.
 - fun_rdy_frm_exe[0]=0 at cycles 1 and 2, =1 at cycle 3.
 - A mult packet offered at cycle 2 is dropped.
REQ-036 Bench SHALL cover branch deferral: alu1 BR=2'b01 idx 12, then br_res_vld 4 cycles later.
 - fun_rdy_frm_exe[1]=0 throughout.
 - clr_br_wat=64'h1000 for exactly 1 cycle after resolve.
REQ-037 Bench SHALL cover a plain add on alu1 (BR=0, JMP=0).
 - FSM stays IDLE; fun_rdy_frm_exe[1] stays 1; clr_br_wat never asserts.
REQ-038 Bench SHALL cover stall: stall_frm_exe=1 for 3 cycles with valid adr packet idx 7 registered.
 - adr_ins_rf held for 3 cycles; fun_rdy_frm_exe=0000 for 3 cycles.
 - Register clears the cycle after the stall drops.
REQ-039 Bench SHALL cover flush with BR_PEND active, mult counter=2, and a simultaneous br_res_vld and new alu2 packet.
 - Next cycle: all vld bits 0, FSM IDLE, clr_br_wat=0, fun_rdy_frm_exe=1111.
REQ-040 Bench SHALL cover reset: assert rst_n=0 mid-BR_PEND, then release.
 - All outputs 0; fun_rdy_frm_exe=1111; no clr_br_wat pulse.
